// File: rtl/exec_cc_if.sv
// Handshake and data bundle between the execute ALU and the condition-code stage.
// Optional macro STAT_EXC_EN adds the per-beat exception status (exc_in).
interface exec_cc_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 4;

  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   icode;
  logic [CW-1:0]   ifun;
  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_b;
  logic [XLEN-1:0] val_e_in;
`ifdef STAT_EXC_EN
  logic            exc_in;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] val_e_out;
  logic            cnd_out;
  logic            zf;
  logic            sf;
  logic            of;

  // Upstream/downstream environment side
  modport master (
    output
`ifdef STAT_EXC_EN
           exc_in,
`endif
           in_valid, icode, ifun, val_a, val_b, val_e_in, out_ready,
    input  in_ready, out_valid, val_e_out, cnd_out, zf, sf, of
  );

  // Stage side
  modport slave (
    input
`ifdef STAT_EXC_EN
           exc_in,
`endif
           in_valid, icode, ifun, val_a, val_b, val_e_in, out_ready,
    output in_ready, out_valid, val_e_out, cnd_out, zf, sf, of
  );
endinterface

// File: rtl/exec_cc_stage.sv
// Y86 execute-stage condition-code unit: one-entry output register that
// passes valE through, updates ZF/SF/OF on OPq beats and evaluates the
// cmovXX/jXX condition against the flags held before the accepting edge.
// Optional macro STAT_EXC_EN: an OPq beat with exc_in=1 leaves the flags alone.
module exec_cc_stage (
  input  logic     clk,
  input  logic     rst_n,
  exec_cc_if.slave bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 4;

  localparam logic [CW-1:0] IC_CMOV = 4'd2;
  localparam logic [CW-1:0] IC_OPQ  = 4'd6;
  localparam logic [CW-1:0] IC_JXX  = 4'd7;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] val_e_q, val_e_d;
  logic            cnd_q, cnd_d;
  logic            zf_q, zf_d;
  logic            sf_q, sf_d;
  logic            of_q, of_d;

  logic accept;
  logic flag_upd;
  logic of_new;
  logic cnd_new;
  logic a_s, b_s, e_s;

  assign a_s = bus.val_a[XLEN-1];
  assign b_s = bus.val_b[XLEN-1];
  assign e_s = bus.val_e_in[XLEN-1];

  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef STAT_EXC_EN
  assign flag_upd = accept && (bus.icode == IC_OPQ) && !bus.exc_in;
`else
  assign flag_upd = accept && (bus.icode == IC_OPQ);
`endif

  // Signed overflow of the ALU op, derived from operand and result signs
  always_comb begin
    of_new = 1'b0;
    case (bus.ifun)
      4'd0:    of_new = (a_s == b_s) && (e_s != a_s);
      4'd1:    of_new = (a_s != b_s) && (e_s != b_s);
      default: of_new = 1'b0;
    endcase
  end

  // Branch/move condition evaluated on the currently held flags
  always_comb begin
    cnd_new = 1'b0;
    if ((bus.icode == IC_CMOV) || (bus.icode == IC_JXX)) begin
      case (bus.ifun)
        4'd0:    cnd_new = 1'b1;
        4'd1:    cnd_new = (sf_q ^ of_q) | zf_q;
        4'd2:    cnd_new = sf_q ^ of_q;
        4'd3:    cnd_new = zf_q;
        4'd4:    cnd_new = !zf_q;
        4'd5:    cnd_new = !(sf_q ^ of_q);
        4'd6:    cnd_new = !(sf_q ^ of_q) && !zf_q;
        default: cnd_new = 1'b0;
      endcase
    end
  end

  // Next state of the output slot and condition-code register
  always_comb begin
    state_d = state_q;
    val_e_d = val_e_q;
    cnd_d   = cnd_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      val_e_d = bus.val_e_in;
      cnd_d   = cnd_new;
    end

    if (flag_upd) begin
      zf_d = (bus.val_e_in == '0);
      sf_d = e_s;
      of_d = of_new;
    end
  end

  // State and output registers; reset drops any held beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      val_e_q <= '0;
      cnd_q   <= 1'b0;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      val_e_q <= val_e_d;
      cnd_q   <= cnd_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.val_e_out = val_e_q;
  assign bus.cnd_out   = cnd_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.of        = of_q;

endmodule

// File: doc/exec_cc_stage.md
EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  upstream beat (ALU result plus decode fields) is valid.
REQ-004 in_ready  output  1  stage can accept a beat this cycle.
REQ-005 icode  input  4  Y86 instruction code of beat.
REQ-006 ifun  input  4  Y86 function code of beat.
REQ-007 val_a  input  64  ALU operand A (valA).
REQ-008 val_b  input  64  ALU operand B (valB).
REQ-009 val_e_in  input  64  ALU result (valE) for operands/ifun above.
REQ-010 exc_in  input  1  beat carries an exception status; present only with STAT_EXC_EN.
REQ-011 out_valid  output  1  registered beat is valid downstream.
REQ-012 out_ready  input  1  downstream accepts the beat this cycle.
REQ-013 val_e_out  output  64  registered valE.
REQ-014 cnd_out  output  1  registered condition result.
REQ-015 zf, sf, of  output  1 each  current condition-code register.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-017 in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-018 Output SHALL be a one-entry register, FSM states EMPTY and FULL: EMPTY -> FULL on accept; FULL -> EMPTY on out_ready without accept; FULL stays FULL on simultaneous out_ready and accept (new beat replaces old).
REQ-019 Latency SHALL be exactly one cycle from accept to out_valid=1 with that beat's data.
REQ-020 While out_valid=1 and out_ready=0, val_e_out and cnd_out SHALL hold stable.
REQ-021 On accept with icode=6 (OPq), zf SHALL load (val_e_in==0), sf SHALL load val_e_in[63].
REQ-022 OF for ifun=0 (add, val_b+val_a) SHALL be 1 iff val_a[63]==val_b[63] and val_e_in[63]!=val_a[63].
REQ-023 OF for ifun=1 (sub, val_b-val_a) SHALL be 1 iff val_a[63]!=val_b[63] and val_e_in[63]!=val_b[63].
REQ-024 OF for ifun=2 (and), ifun=3 (xor) and any other ifun SHALL be 0.
REQ-025 Flags SHALL not change on any cycle without an OPq accept.
REQ-026 cnd for icode=2 (cmovXX) or 7 (jXX) SHALL use flags as held before the accepting edge: ifun 0 -> 1; 1 le -> (sf^of)|zf; 2 l -> sf^of; 3 e -> zf; 4 ne -> !zf; 5 ge -> !(sf^of); 6 g -> !(sf^of)&!zf; ifun 7-15 -> 0.
REQ-027 cnd for all other icodes SHALL be 0.
REQ-028 A conditional beat accepted the cycle after an OPq accept SHALL see the OPq's updated flags.
REQ-029 val_e_out SHALL equal val_e_in unmodified, all icodes.

Reset
REQ-030 rst_n=0 SHALL immediately force FSM to EMPTY, out_valid=0, val_e_out=0, cnd_out=0, zf=1, sf=0, of=0.
REQ-031 A beat held in FULL when reset asserts SHALL be discarded, never presented.
REQ-032 No accept SHALL occur on the first edge at which rst_n is still 0.

Configuration
REQ-033 Macro STAT_EXC_EN: when defined, exc_in exists and an OPq accept with exc_in=1 SHALL leave zf/sf/of unchanged while still passing the beat through.
REQ-034 Without STAT_EXC_EN, exc_in SHALL be absent and every OPq accept SHALL update flags.

Verification
REQ-035 Reset release, no traffic -> zf=1, sf=0, of=0, out_valid=0, in_ready=1.
REQ-036 OPq add a=64'h7FFF_FFFF_FFFF_FFFF, b=1, valE=64'h8000_0000_0000_0000 -> zf=0, sf=1, of=1; next beat jXX ifun=2 -> cnd_out=0 (sf^of=0).
REQ-037 OPq and a=10, b=5, valE=0 -> zf=1, sf=0, of=0; next cmovXX ifun=3 -> cnd_out=1; ifun=4 -> cnd_out=0.
REQ-038 out_ready=0 for 3 cycles with beat valE=0x1234 -> out_valid=1, val_e_out=0x1234 held, in_ready=0; out_ready=1 with new in_valid -> replaced in one cycle, no gap.
REQ-039 rst_n pulsed low mid-FULL -> out_valid=0 immediately, flags at reset values, no stale beat after release.
REQ-040 With STAT_EXC_EN, OPq sub a=1, b=1, valE=0, exc_in=1 after flags zf=0, sf=1 -> flags stay zf=0, sf=1, of=0; beat emitted with val_e_out=0.
